// File: rtl/aes_key_expand_seq_if.sv
// Handshake bundle between the AES-128 key schedule and the round controller.
interface aes_key_expand_seq_if;
  logic         start;
  logic [127:0] key_in;
  logic [127:0] round_key;
  logic [3:0]   round_num;
  logic         key_valid;
  logic         key_ready;
  logic         busy;
  logic         done;

  modport master (
    output start, key_in, key_ready,
    input  round_key, round_num, key_valid, busy, done
  );

  modport slave (
    input  start, key_in, key_ready,
    output round_key, round_num, key_valid, busy, done
  );
endinterface

// File: rtl/aes_key_expand_seq.sv
// Iterative AES-128 key schedule, round keys 0..10 over a valid/ready bus.
// Optional: ROUND_KEY_ZEROIZE_EN clears round_key when the schedule finishes.
module aes_key_expand_seq #(
  parameter int SBOX_PIPE = 0
) (
  input  logic clk,
  input  logic rst_n,
  aes_key_expand_seq_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    PRESENT,
    COMPUTE,
    FINISH
  } state_t;

  localparam bit PIPE = (SBOX_PIPE != 0);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
    8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
    8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
    8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
    8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
    8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
    8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
    8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
    8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
    8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
    8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
    8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
    8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
    8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
    8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
    8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
    8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  state_t       state, state_nx;
  logic [127:0] rk_q, rk_nx;
  logic [3:0]   rn_q, rn_nx;
  logic [7:0]   rcon_q, rcon_nx;
  logic [7:0]   rcon_adv;
  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  rot, sub_c, sub_w, t;
  logic [31:0]  n0, n1, n2, n3;
  logic [127:0] next_key;

  assign {w0, w1, w2, w3} = rk_q;
  assign rot = {w3[23:0], w3[31:24]};

  assign sub_c = {SBOX[rot[31:24]], SBOX[rot[23:16]],
                  SBOX[rot[15:8]],  SBOX[rot[7:0]]};

  // Pipelined SubWord: rk_q is frozen across PRESENT->COMPUTE,
  // so the registered word always matches the key being expanded.
  generate
    if (PIPE) begin : g_pipe
      logic [31:0] sw_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sw_q <= '0;
        else        sw_q <= sub_c;
      end
      assign sub_w = sw_q;
    end else begin : g_comb
      assign sub_w = sub_c;
    end
  endgenerate

  assign t  = sub_w ^ {rcon_q, 24'h0};
  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;
  assign next_key = {n0, n1, n2, n3};

  assign rcon_adv = {rcon_q[6:0], 1'b0}
                  ^ (rcon_q[7] ? 8'h1b : 8'h00);

  always_comb begin
    state_nx = state;
    rk_nx    = rk_q;
    rn_nx    = rn_q;
    rcon_nx  = rcon_q;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          rk_nx    = bus.key_in;
          rn_nx    = 4'd0;
          rcon_nx  = 8'h01;
          state_nx = PRESENT;
        end
      end
      PRESENT: begin
        if (bus.key_ready) begin
          if (rn_q == 4'd10) begin
            state_nx = FINISH;
`ifdef ROUND_KEY_ZEROIZE_EN
            rk_nx = '0;
`endif
          end else if (!PIPE) begin
            rk_nx   = next_key;
            rn_nx   = rn_q + 4'd1;
            rcon_nx = rcon_adv;
          end else begin
            state_nx = COMPUTE;
          end
        end
      end
      COMPUTE: begin
        rk_nx    = next_key;
        rn_nx    = rn_q + 4'd1;
        rcon_nx  = rcon_adv;
        state_nx = PRESENT;
      end
      FINISH: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      rk_q   <= '0;
      rn_q   <= '0;
      rcon_q <= 8'h01;
    end else begin
      state  <= state_nx;
      rk_q   <= rk_nx;
      rn_q   <= rn_nx;
      rcon_q <= rcon_nx;
    end
  end

  assign bus.round_key = rk_q;
  assign bus.round_num = rn_q;
  assign bus.key_valid = (state == PRESENT);
  assign bus.busy      = (state == PRESENT) || (state == COMPUTE);
  assign bus.done      = (state == FINISH);

endmodule

// File: tb/tb_aes_key_expand_seq.sv
// Scoreboard bench: SBOX_PIPE=0 and SBOX_PIPE=1 instances vs a FIPS-197 model.
module tb_aes_key_expand_seq;

  typedef logic [127:0] keys_t [11];

  localparam logic [127:0] FK  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] R1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] K2  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K2R10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
`ifdef ROUND_KEY_ZEROIZE_EN
  localparam logic [127:0] HOLD = 128'h0;
`else
  localparam logic [127:0] HOLD = R10;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  aes_key_expand_seq_if i0 ();
  aes_key_expand_seq_if i1 ();

  aes_key_expand_seq #(.SBOX_PIPE(0)) u0 (
    .clk(clk), .rst_n(rst_n), .bus(i0)
  );
  aes_key_expand_seq #(.SBOX_PIPE(1)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(i1)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit rnd = 1'b0;
  logic [7:0] sb [256];
  logic [131:0] q0 [$];
  logic [131:0] q1 [$];
  logic [127:0] got [2][11];
  int t0 [2];
  int t10 [2];
  int ndone [2];
  bit last10 [2];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box from its definition: GF(2^8) inverse then the affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int x = 1; x < 256; x++)
        if (gmul(a[7:0], x[7:0]) == 8'h01) inv = x[7:0];
      sb[a] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
            ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  function automatic keys_t expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0] rc [10];
    keys_t k;
    rc = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
           8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]}
          ^ {rc[i/4-1], 24'h0};
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++)
      k[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return k;
  endfunction

  task automatic push(input int d, input logic [127:0] key);
    keys_t k;
    k = expand(key);
    for (int r = 0; r < 11; r++)
      if (d == 0) q0.push_back({4'(r), k[r]});
      else        q1.push_back({4'(r), k[r]});
  endtask

  task automatic chk(input string n, input logic [127:0] g, input logic [127:0] e);
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL %s got %h want %h", n, g, e);
    end
  endtask

  task automatic mon(input int d, input logic v, input logic r,
                     input logic dn, input logic bz,
                     input logic [127:0] rk, input logic [3:0] rn);
    logic [131:0] e;
    if (dn || last10[d]) begin
      checks++;
      if (dn !== last10[d] || bz !== 1'b0) begin
        errors++;
        $display("FAIL done%0d got done=%b busy=%b want done=%b busy=0",
                 d, dn, bz, last10[d]);
      end
    end
    if (dn) ndone[d]++;
    last10[d] = v && r && (rn == 4'd10);
    if (v === 1'b1 && r === 1'b1) begin
      e = 'x;
      if (d == 0 && q0.size() > 0) e = q0.pop_front();
      if (d == 1 && q1.size() > 0) e = q1.pop_front();
      checks++;
      if ({rn, rk} !== e) begin
        errors++;
        $display("FAIL key%0d got %0d:%h want %h", d, rn, rk, e);
      end
      if (rn <= 4'd10) got[d][rn] = rk;
      if (rn == 4'd0) t0[d] = cyc;
      if (rn == 4'd10) t10[d] = cyc;
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      mon(0, i0.key_valid, i0.key_ready, i0.done, i0.busy,
          i0.round_key, i0.round_num);
      mon(1, i1.key_valid, i1.key_ready, i1.done, i1.busy,
          i1.round_key, i1.round_num);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd) begin
      i0.key_ready = 1'($urandom);
      i1.key_ready = 1'($urandom);
    end
  endtask

  task automatic kick(input bit a, input bit b, input logic [127:0] key);
    tick();
    i0.start = a;
    i1.start = b;
    i0.key_in = key;
    i1.key_in = key;
    if (a) push(0, key);
    if (b) push(1, key);
    tick();
    i0.start = 1'b0;
    i1.start = 1'b0;
    i0.key_in = {$urandom, $urandom, $urandom, $urandom};
    i1.key_in = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (n < 400 && (q0.size() != 0 || q1.size() != 0 ||
           i0.busy || i1.busy || i0.done || i1.done)) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 400) begin
      errors++;
      $display("FAIL %s timeout left %0d/%0d want 0/0",
               tag, q0.size(), q1.size());
    end
  endtask

  task automatic wait_round(input int r, input string tag);
    int n;
    n = 0;
    while (n < 100 && !(i0.key_valid && i0.round_num == 4'(r))) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 100) begin
      errors++;
      $display("FAIL %s never reached round %0d", tag, r);
    end
  endtask

  task automatic rst_chk(input string tag);
    chk({tag, "0"}, {i0.round_key, i0.round_num, i0.key_valid, i0.busy, i0.done}, '0);
    chk({tag, "1"}, {i1.round_key, i1.round_num, i1.key_valid, i1.busy, i1.done}, '0);
  endtask

  initial begin
    keys_t ek;
    int nd0, nd1;
    build_sbox();
    i0.start = 1'b0; i1.start = 1'b0;
    i0.key_in = '0;  i1.key_in = '0;
    i0.key_ready = 1'b1; i1.key_ready = 1'b1;
    for (int d = 0; d < 2; d++) begin
      ndone[d] = 0; last10[d] = 1'b0; t0[d] = 0; t10[d] = 0;
    end
    repeat (3) tick();
    rst_chk("reset");
    rst_n = 1'b1;

    // Known-answer run, full-speed consumer on both instances.
    kick(1, 1, FK);
    wait_idle("kat");
    chk("kat_r0", got[0][0], FK);
    chk("kat_r1", got[0][1], R1);
    chk("kat_r10", got[0][10], R10);
    chk("kat_p1_r10", got[1][10], R10);
    chk("lat_pipe0", 128'(t10[0] - t0[0]), 128'd10);
    chk("lat_pipe1", 128'(t10[1] - t0[1]), 128'd20);
    chk("ndone", {96'h0, 16'(ndone[0]), 16'(ndone[1])}, {96'h0, 16'd1, 16'd1});
    chk("hold0", i0.round_key, HOLD);
    chk("hold1", i1.round_key, HOLD);
    chk("hold_rn", {i0.round_num, i1.round_num}, {4'd10, 4'd10});

    // Backpressure at round 3 on the combinational instance.
    ek = expand(FK);
    kick(1, 0, FK);
    wait_round(2, "bp");
    tick();
    i0.key_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_stall", {i0.key_valid, i0.round_num, i0.round_key}, {1'b1, 4'd3, ek[3]});
      tick();
    end
    i0.key_ready = 1'b1;
    chk("bp_last", {i0.key_valid, i0.round_num, i0.round_key}, {1'b1, 4'd3, ek[3]});
    tick();
    chk("bp_next", {i0.key_valid, i0.round_num, i0.round_key}, {1'b1, 4'd4, ek[4]});
    wait_idle("bp");
    chk("bp_r10", got[0][10], R10);

    // start while busy must be ignored.
    rnd = 1'b1;
    kick(1, 1, FK);
    wait_round(2, "ign");
    i0.start = 1'b1;
    i1.start = i1.busy;
    i0.key_in = K2;
    i1.key_in = K2;
    tick();
    i0.start = 1'b0;
    i1.start = 1'b0;
    wait_idle("ign");
    chk("ign_r10_0", got[0][10], R10);
    chk("ign_r10_1", got[1][10], R10);

    // Asynchronous reset mid-expansion.
    rnd = 1'b0;
    i0.key_ready = 1'b1;
    i1.key_ready = 1'b1;
    kick(1, 1, {$urandom, $urandom, $urandom, $urandom});
    wait_round(6, "rst");
    #3 rst_n = 1'b0;
    #1 rst_chk("midrst");
    q0.delete();
    q1.delete();
    last10[0] = 1'b0;
    last10[1] = 1'b0;
    nd0 = ndone[0];
    nd1 = ndone[1];
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    rst_chk("postrst");
    chk("rst_nodone", {96'h0, 16'(ndone[0]), 16'(ndone[1])}, {96'h0, 16'(nd0), 16'(nd1)});
    kick(1, 1, K2);
    wait_idle("k2");
    chk("k2_r0", got[0][0], K2);
    chk("k2_r10_0", got[0][10], K2R10);
    chk("k2_r10_1", got[1][10], K2R10);

    // Random keys under random backpressure.
    rnd = 1'b1;
    for (int i = 0; i < 4; i++) begin
      kick(1, 1, {$urandom, $urandom, $urandom, $urandom});
      wait_idle("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
